// File: rtl/prog_counter.sv
// Program-counter register stage: selects PC+1 or PC+offset each cycle,
// sequences start/halt, flags out-of-range PC updates and counts retired
// instructions.
module prog_counter #(
  parameter int unsigned D  = 12,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  input  logic          stall,
  input  logic          halt_req,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          overflow_err,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e        r_state, w_state_d;
  logic [D-1:0]  r_pc, w_pc_d;
  logic          r_ovf, w_ovf_d;
  logic [CW-1:0] r_cnt, w_cnt_d;

  // Two guard bits: zero-extended PC plus sign-extended offset spans
  // -2^(D-1) .. 2^D + 2^(D-1) - 2, which needs D+2 bits to be exact.
  logic [D+1:0]  w_step;
  logic [D+1:0]  w_sum;
  logic          w_range_err;
  logic [CW-1:0] w_cnt_inc;

  assign w_step      = branch_en ? {{2{target[D-1]}}, target} : (D+2)'(1);
  assign w_sum       = {2'b00, r_pc} + w_step;
  // Any set guard bit means the result was negative or above 2^D-1.
  assign w_range_err = |w_sum[D+1:D];
  // Saturating retire count.
  assign w_cnt_inc   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_ovf   <= w_ovf_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state and datapath selection: halt_req > stall > branch > increment.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_ovf_d   = r_ovf;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle, StHalted: begin
        if (start) begin
          w_state_d = StRun;
          w_pc_d    = start_addr;
          w_ovf_d   = 1'b0;
          w_cnt_d   = '0;
        end
      end
      StRun: begin
        if (halt_req) begin
          w_state_d = StHalted;
          w_cnt_d   = w_cnt_inc;
        end else if (!stall) begin
          w_pc_d  = w_sum[D-1:0];
          w_ovf_d = r_ovf | w_range_err;
          w_cnt_d = w_cnt_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign prog_ctr     = r_pc;
  assign running      = (r_state == StRun);
  assign done         = (r_state == StHalted);
  assign overflow_err = r_ovf;
  assign instr_count  = r_cnt;

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter.
module tb_prog_counter;

  localparam int unsigned D  = 12;
  localparam int unsigned CW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [D-1:0]  start_addr;
  logic          branch_en;
  logic [D-1:0]  target;
  logic          stall;
  logic          halt_req;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          overflow_err;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  prog_counter #(.D(D), .CW(CW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .start_addr   (start_addr),
    .branch_en    (branch_en),
    .target       (target),
    .stall        (stall),
    .halt_req     (halt_req),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done),
    .overflow_err (overflow_err),
    .instr_count  (instr_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full visible state in one go.
  task automatic check_all(input string tag, input logic [D-1:0] pc, input logic run,
                           input logic dn, input logic ovf, input logic [CW-1:0] cnt);
    check({tag, ".pc"},   32'(prog_ctr),     32'(pc));
    check({tag, ".run"},  32'(running),      32'(run));
    check({tag, ".done"}, 32'(done),         32'(dn));
    check({tag, ".ovf"},  32'(overflow_err), 32'(ovf));
    check({tag, ".cnt"},  32'(instr_count),  32'(cnt));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; start_addr = '0; branch_en = 0; target = '0; stall = 0; halt_req = 0;
  endtask

  initial begin
    Reset = 1'b0;
    clear_inputs();
    #2;
    check_all("reset", 12'h000, 0, 0, 0, 0);
    #10;
    Reset = 1'b1;
    step();

    // IDLE ignores everything but start
    branch_en = 1; target = 12'h010; halt_req = 1; stall = 1;
    step();
    check_all("idle_ignore", 12'h000, 0, 0, 0, 0);
    clear_inputs();

    // start at 0x0C8, then branch by 0xF9B (-101) -> 0x063
    start = 1; start_addr = 12'h0C8;
    step();
    check_all("start_c8", 12'h0C8, 1, 0, 0, 0);
    clear_inputs();
    branch_en = 1; target = 12'hF9B;
    step();
    check_all("br_neg", 12'h063, 1, 0, 0, 1);
    // 0x063 - 44 (0xFD4) -> 0x037
    target = 12'hFD4;
    step();
    check_all("br_to_37", 12'h037, 1, 0, 0, 2);
    clear_inputs();

    // asynchronous reset mid-RUN, away from the clock edge
    #2;
    Reset = 1'b0;
    #1;
    check_all("async_rst", 12'h000, 0, 0, 0, 0);
    start = 1; start_addr = 12'h055;
    step();
    check_all("start_in_rst", 12'h000, 0, 0, 0, 0);
    Reset = 1'b1;
    clear_inputs();

    // underflow: 0x003 - 6 -> 0xFFD with sticky error
    start = 1; start_addr = 12'h003;
    step();
    check_all("start_003", 12'h003, 1, 0, 0, 0);
    clear_inputs();
    branch_en = 1; target = 12'hFFA;
    step();
    check_all("underflow", 12'hFFD, 1, 0, 1, 1);
    clear_inputs();
    for (int i = 0; i < 10; i++) step();
    // 0xFFD + 10 wraps to 0x007; flag stays set
    check_all("sticky10", 12'h007, 1, 0, 1, 11);

    // halt, then restart at 0xFFF and increment-wrap to 0x000
    halt_req = 1;
    step();
    check_all("halt1", 12'h007, 0, 1, 1, 12);
    clear_inputs();
    step();
    check_all("halted_hold", 12'h007, 0, 1, 1, 12);
    start = 1; start_addr = 12'hFFF;
    step();
    check_all("start_fff", 12'hFFF, 1, 0, 0, 0);
    clear_inputs();
    step();
    check_all("inc_wrap", 12'h000, 1, 0, 1, 1);

    // start ignored in RUN
    start = 1; start_addr = 12'h500;
    step();
    check_all("start_in_run", 12'h001, 1, 0, 1, 2);

    // halt_req beats stall, branch and start together
    halt_req = 1; stall = 1; branch_en = 1; target = 12'h020;
    step();
    check_all("halt_prio", 12'h001, 0, 1, 1, 3);
    clear_inputs();

    // restart clears error and count
    start = 1; start_addr = 12'h100;
    step();
    check_all("start_100", 12'h100, 1, 0, 0, 0);
    clear_inputs();

    // stall with branch pending: frozen, then +9 once
    stall = 1; branch_en = 1; target = 12'h009;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 12'h100, 1, 0, 0, 0);
    end
    stall = 0;
    step();
    check_all("stall_rel", 12'h109, 1, 0, 0, 1);

    // branch by zero holds PC, retires, no error
    target = 12'h000;
    step();
    check_all("br_zero", 12'h109, 1, 0, 0, 2);

    // positive overflow: 0x109 + 0x7FF = 0x908 (no error), then 0x908 + 0x7FF -> 0x107 wrapped
    target = 12'h7FF;
    step();
    check_all("br_pos", 12'h908, 1, 0, 0, 3);
    step();
    check_all("br_ovf", 12'h107, 1, 0, 1, 4);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
